// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolve adder.
//   CSA_WIDTH / CSA_CHUNK : default operand width and bits resolved per cycle
//   state_e               : controller states
//   idx_width()           : width of the chunk index register for a given chunk count
package csa_pkg;
  localparam int CSA_WIDTH = 64;
  localparam int CSA_CHUNK = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Never returns 0 so a single-chunk configuration still gets a legal vector.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction
endpackage

// File: rtl/csa_resolve_if.sv
// Operand/result handshake bundle for csa_resolve.
//   in_valid/in_ready/in_sum/in_carry       : carry-save pair from the compressor
//   out_valid/out_ready/out_result/out_cout : resolved binary result
// master = producer/consumer side, slave = the resolve adder.
interface csa_resolve_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_cout;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_cout
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_cout
  );
endinterface

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry adder built from fulladder cells.
//   a_i, b_i : CHUNK-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : CHUNK-bit sum
//   cout_o   : carry out of bit CHUNK-1
module chunk_adder
  import csa_pkg::*;
#(
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);
  logic [CHUNK:0] c;

  assign c[0] = cin_i;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    fulladder u_fa (
      .a_i  (a_i[g]),
      .b_i  (b_i[g]),
      .ci_i (c[g]),
      .s_o  (sum_o[g]),
      .co_o (c[g+1])
    );
  end

  assign cout_o = c[CHUNK];
endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell.
//   a_i, b_i, ci_i : addends and carry in
//   s_o, co_o      : sum and carry out
module fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule

// File: rtl/csa_resolve.sv
// Multi-cycle carry-resolve adder: accepts a carry-save (sum, carry) pair and
// ripple-adds it CHUNK bits per cycle, low chunk first, producing
// (sum + carry) mod 2^WIDTH and the carry out of the top bit.
// WIDTH must be a multiple of CHUNK.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops any in-flight transaction
//   bus   : csa_resolve_if slave (operand handshake in, result handshake out)
// in_ready/out_valid decode from state only; result/cout are registers, so
// there is no combinational path from any input to any output.
module csa_resolve
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int CHUNK = CSA_CHUNK
) (
  input  logic          clk,
  input  logic          rst_n,
  csa_resolve_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] opa_q,    opa_d;
  logic [WIDTH-1:0] opb_q,    opb_d;
  logic [IW-1:0]    idx_q,    idx_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;

  // One adder is shared across all chunks; the index steers which slice it sees.
  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a_i    (opa_q[idx_q*CHUNK +: CHUNK]),
    .b_i    (opb_q[idx_q*CHUNK +: CHUNK]),
    .cin_i  (carry_q),
    .sum_o  (chunk_sum),
    .cout_o (chunk_cout)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opa_d    = bus.in_sum;
          opb_d    = bus.in_carry;
          carry_d  = 1'b0;
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        result_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
        carry_d = chunk_cout;
        if (idx_q == LAST_IDX) begin
          // Explicit wrap keeps the index legal when NCHUNK is not a power of two.
          idx_d   = '0;
          cout_d  = chunk_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_cout   = cout_q;
endmodule

// File: tb/tb_csa_resolve.sv
module tb_csa_resolve;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  csa_resolve_if #(.WIDTH(64)) bus ();

  csa_resolve #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pair, wait (bounded) for acceptance, then drop in_valid.
  task automatic send(input logic [63:0] s, input logic [63:0] c);
    int n;
    n = 0;
    bus.in_sum   = s;
    bus.in_carry = c;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", bus.out_cout); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc;
    bus.out_ready = 1'b0;
    send(64'h1, 64'h1);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_busy_ready: got %b want 0", bus.in_ready); end
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL single_latency: got %0d want 4", cyc); end
    checks++; if (bus.out_result !== 64'h2) begin errors++; $display("FAIL single_result: got %h want 2", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL single_cout: got %b want 0", bus.out_cout); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b0;
  endtask

  // out_ready held high the whole time: early assertion must not matter.
  task automatic test_cross_chunk();
    int cyc;
    bus.out_ready = 1'b1;
    send(64'h0000_0000_0000_FFFF, 64'h1);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL cross_early_valid: got %b want 0", bus.out_valid); end
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL cross_latency: got %0d want 4", cyc); end
    checks++; if (bus.out_result !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL cross_result: got %h want 10000", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL cross_cout: got %b want 0", bus.out_cout); end
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL cross_return: ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_ripple();
    int cyc;
    bus.out_ready = 1'b0;
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_valid(cyc);
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL ripple_result: got %h want 0", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b1) begin errors++; $display("FAIL ripple_cout: got %b want 1", bus.out_cout); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001);
    wait_valid(cyc);
    // Offer a different pair while stalled; it must be ignored.
    bus.in_sum   = 64'h1111;
    bus.in_carry = 64'h2222;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
      checks++; if (bus.out_result !== 64'h1) begin errors++; $display("FAIL bp_result[%0d]: got %h want 1", i, bus.out_result); end
      checks++; if (bus.out_cout !== 1'b1) begin errors++; $display("FAIL bp_cout[%0d]: got %b want 1", i, bus.out_cout); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    bus.out_ready = 1'b0;
    send(64'h0000_0000_1111_2222, 64'h0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL midrst_result: got %h want 0", bus.out_result); end
    #2 rst_n = 1'b1;
    send(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1110);
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL midrst_latency: got %0d want 4", cyc); end
    checks++; if (bus.out_result !== 64'h1234_5678_9ABC_DEFF) begin errors++; $display("FAIL midrst_result2: got %h want 123456789abcdeff", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL midrst_cout2: got %b want 0", bus.out_cout); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // in_valid and out_ready held high: accepts land NCHUNK+2 edges apart.
  task automatic test_back_to_back();
    int cyc;
    bus.out_ready = 1'b1;
    bus.in_sum    = 64'h5;
    bus.in_carry  = 64'h6;
    bus.in_valid  = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready=%b want 0", bus.in_ready); end
    bus.in_sum   = 64'hFFFF_0000_FFFF_0000;
    bus.in_carry = 64'h0001_0000_0001_0000;
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_latency_a: got %0d want 4", cyc); end
    checks++; if (bus.out_result !== 64'hB) begin errors++; $display("FAIL b2b_result_a: got %h want b", bus.out_result); end
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: in_ready=%b want 0", bus.in_ready); end
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_latency_b: got %0d want 4", cyc); end
    checks++; if (bus.out_result !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL b2b_result_b: got %h want 100000000", bus.out_result); end
    checks++; if (bus.out_cout !== 1'b1) begin errors++; $display("FAIL b2b_cout_b: got %b want 1", bus.out_cout); end
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Random X,Y,Z through a 3:2 compressor model, random stalls on both sides.
  task automatic test_random();
    logic [63:0] expq[$];
    logic        coutq[$];
    logic [63:0] x, y, z, s, c, cur_exp, e;
    logic [64:0] wide;
    logic        cur_cout, ec;
    int          sent, rcvd, cyc;
    sent = 0; rcvd = 0; cyc = 0;
    cur_exp = '0; cur_cout = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    while (rcvd < 1000 && cyc < 40000) begin
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(cur_exp);
        coutq.push_back(cur_cout);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: result %h with nothing outstanding", bus.out_result);
        end else begin
          e  = expq.pop_front();
          ec = coutq.pop_front();
          if (bus.out_result !== e) begin errors++; $display("FAIL rand_result[%0d]: got %h want %h", rcvd, bus.out_result, e); end
          checks++;
          if (bus.out_cout !== ec) begin errors++; $display("FAIL rand_cout[%0d]: got %b want %b", rcvd, bus.out_cout, ec); end
        end
        rcvd++;
      end
      tick();
      cyc++;
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        z = {$urandom, $urandom};
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        wide     = {1'b0, s} + {1'b0, c};
        cur_exp  = x + y + z;
        cur_cout = wide[64];
        bus.in_sum   = s;
        bus.in_carry = c;
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (rcvd != 1000) begin errors++; $display("FAIL rand_count: received %0d want 1000", rcvd); end
    checks++; if (sent != 1000 || expq.size() != 0) begin errors++; $display("FAIL rand_balance: sent %0d outstanding %0d want 1000/0", sent, expq.size()); end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    test_reset();
    test_single();
    test_cross_chunk();
    test_full_ripple();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
